// File: rtl/iir_biquad_seq.sv
// Direct-form-I IIR biquad sequencer. One shared multiplier-accumulator is
// stepped through the five taps b0,b1,b2,a1,a2. The result is then rounded
// and saturated, the x/y delay line is updated, and the output sample is
// handed downstream over a valid/ready handshake.
module iir_biquad_seq #(
  parameter int INT_BITS  = 12,
  parameter int FRAC_BITS = 16,
  localparam int W        = INT_BITS + FRAC_BITS + 1,
  localparam int ACC_W    = 2 * (INT_BITS + FRAC_BITS) + 1 + 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] m_data,
  input  logic                coef_we,
  input  logic [2:0]          coef_addr,
  input  logic signed [W-1:0] coef_data,
  input  logic                clear,
  output logic                busy,
  output logic                sat
);

  typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_e;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic [2:0]                tap_q, tap_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [W-1:0]       x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [W-1:0]       y1_q, y1_d, y2_q, y2_d;
  logic signed [W-1:0]       coef_q [5];
  logic signed [W-1:0]       coef_d [5];
  logic                      s_ready_q, s_ready_d;
  logic                      m_valid_q, m_valid_d;
  logic signed [W-1:0]       m_data_q, m_data_d;
  logic                      sat_q, sat_d;

  logic signed [W-1:0]       mul_a, mul_b;
  logic [2*W-1:0]            prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   rnd_sum, r;
  logic                      clamp;
  logic signed [W-1:0]       y_new;

  // Select the coefficient/delay-state pair for the current tap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    mul_a = '0;
    mul_b = '0;
    case (tap_q)
      3'd0: begin mul_a = coef_q[0]; mul_b = x0_q; end
      3'd1: begin mul_a = coef_q[1]; mul_b = x1_q; end
      3'd2: begin mul_a = coef_q[2]; mul_b = x2_q; end
      3'd3: begin mul_a = coef_q[3]; mul_b = y1_q; end
      3'd4: begin mul_a = coef_q[4]; mul_b = y2_q; end
      default: ;
    endcase
  end

  // Full signed product: the low 2W bits of the sign-extended operands'
  // product equal the signed W x W product, then extend into the guard bits.
  assign prod     = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
  assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};

  // Round half up, drop the fraction, clamp to the sample range.
  assign rnd_sum = acc_q + RND_HALF;
  assign r       = rnd_sum >>> FRAC_BITS;
  always_comb begin
    clamp = 1'b0;
    y_new = r[W-1:0];
    if (r > Y_MAX) begin
      clamp = 1'b1;
      y_new = Y_MAX[W-1:0];
    end else if (r < Y_MIN) begin
      clamp = 1'b1;
      y_new = Y_MIN[W-1:0];
    end
  end

  // Sequencer next-state, datapath updates and coefficient writes.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    coef_d    = coef_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    sat_d     = sat_q;

    case (state_q)
      IDLE: begin
        // s_ready comes up one edge after reset release and stays up here.
        s_ready_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
          if (coef_we && coef_addr == 3'(i)) coef_d[i] = coef_data;
        end
        if (s_valid && s_ready_q) begin
          x0_d      = s_data;
          acc_d     = '0;
          tap_d     = '0;
          s_ready_d = 1'b0;
          state_d   = MAC;
        end
      end
      MAC: begin
        // Feedback taps (a1, a2) are subtracted.
        acc_d = (tap_q >= 3'd3) ? acc_q - prod_ext : acc_q + prod_ext;
        if (tap_q == 3'd4) state_d = RND;
        else               tap_d   = tap_q + 3'd1;
      end
      RND: begin
        m_data_d  = y_new;
        sat_d     = sat_q | clamp;
        x2_d      = x1_q;
        x1_d      = x0_q;
        y2_d      = y1_q;
        y1_d      = y_new;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything else; coefficients survive it.
    if (clear) begin
      state_d   = IDLE;
      tap_d     = '0;
      acc_d     = '0;
      x0_d      = '0;
      x1_d      = '0;
      x2_d      = '0;
      y1_d      = '0;
      y2_d      = '0;
      coef_d    = coef_q;
      sat_d     = 1'b0;
      m_valid_d = 1'b0;
      s_ready_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      acc_q     <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      // NOTE: the coefficient bank is a handful of flops that must read as
      // zero after reset, so it is reset like any other register rather
      // than treated as an unreset memory.
      for (int i = 0; i < 5; i++) coef_q[i] <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sat_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed in the combinational blocks.
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      coef_q    <= coef_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      sat_q     <= sat_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = (state_q != IDLE);
  assign sat     = sat_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed bench for iir_biquad_seq: passthrough, recursion, saturation,
// backpressure, abort with dropped coefficient write, and async reset.
module tb_iir_biquad_seq;

  localparam int W = 29;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [W-1:0] m_data;
  logic         coef_we = 1'b0;
  logic [2:0]   coef_addr = '0;
  logic [W-1:0] coef_data = '0;
  logic         clear = 1'b0;
  logic         busy;
  logic         sat;

  int checks = 0;
  int errors = 0;

  iir_biquad_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .clear     (clear),
    .busy      (busy),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sample and drive 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [W-1:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    step();
    coef_we   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Accept one sample, then wait (bounded) for m_valid and check latency/data.
  task automatic send_wait(input logic [W-1:0] x, input logic [W-1:0] exp_y, input string tag);
    int guard = 0;
    int lat = 0;
    while (!s_ready && guard < 50) begin
      step();
      guard++;
    end
    s_valid = 1'b1;
    s_data  = x;
    step();
    s_valid = 1'b0;
    while (!m_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd6);
    check({tag, "_data"}, 64'(m_data), 64'(exp_y));
  endtask

  // Complete the output handshake with m_ready high.
  task automatic take_output(input string tag);
    m_ready = 1'b1;
    step();
    check({tag, "_mvalid_drop"}, 64'(m_valid), 64'd0);
    check({tag, "_sready_up"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    step();
    step();
    resetn = 1'b1;
    check("rel_s_ready_before_edge", 64'(s_ready), 64'd0);
    step();
    check("rel_s_ready_after_edge", 64'(s_ready), 64'd1);

    // Passthrough: b0 = 1.0
    write_coef(3'd0, 29'h0010000);
    send_wait(29'h0030000, 29'h0030000, "pass");
    check("pass_sat", 64'(sat), 64'd0);
    check("pass_busy", 64'(busy), 64'd1);
    take_output("pass");

    // Recursion: y = x + 0.5*y1 from a cleared state
    write_coef(3'd3, 29'h1FFF8000);
    pulse_clear();
    check("clr_idle_busy", 64'(busy), 64'd0);
    send_wait(29'h0010000, 29'h0010000, "rec0");
    take_output("rec0");
    send_wait(29'h0000000, 29'h0008000, "rec1");
    take_output("rec1");
    send_wait(29'h0000000, 29'h0004000, "rec2");
    take_output("rec2");
    send_wait(29'h0000000, 29'h0002000, "rec3");
    take_output("rec3");

    // Saturation: 100 * 100 exceeds the range on both sides
    write_coef(3'd3, 29'h0000000);
    write_coef(3'd0, 29'h0640000);
    pulse_clear();
    send_wait(29'h0640000, 29'h0FFFFFFF, "sat_pos");
    check("sat_pos_flag", 64'(sat), 64'd1);
    take_output("sat_pos");
    pulse_clear();
    check("sat_cleared", 64'(sat), 64'd0);
    send_wait(29'h1F9C0000, 29'h10000000, "sat_neg");
    check("sat_neg_flag", 64'(sat), 64'd1);
    take_output("sat_neg");

    // Backpressure: hold the output for 10 cycles
    write_coef(3'd0, 29'h0010000);
    pulse_clear();
    m_ready = 1'b0;
    send_wait(29'h0020000, 29'h0020000, "bp");
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_mvalid", 64'(m_valid), 64'd1);
      check("bp_hold_mdata", 64'(m_data), 64'h20000);
      check("bp_hold_sready", 64'(s_ready), 64'd0);
    end
    take_output("bp");
    step();
    check("bp_no_dup", 64'(m_valid), 64'd0);

    // Abort mid-MAC with a coefficient write attempted while busy
    write_coef(3'd1, 29'h0010000);
    s_valid = 1'b1;
    s_data  = 29'h0070000;
    step();
    s_valid = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 29'h0123456;
    step();
    coef_we = 1'b0;
    step();
    step();
    pulse_clear();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_s_ready", 64'(s_ready), 64'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (m_valid) seen++;
        step();
      end
      check("abort_no_output", 64'(seen), 64'd0);
    end
    send_wait(29'h0010000, 29'h0010000, "after_abort");
    take_output("after_abort");
    send_wait(29'h0000000, 29'h0010000, "b1_tap");
    take_output("b1_tap");

    // Async reset while in OUT
    m_ready = 1'b0;
    send_wait(29'h0010000, 29'h0010000, "pre_rst");
    #3;
    resetn = 1'b0;
    #1;
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_m_data", 64'(m_data), 64'd0);
    check("arst_s_ready", 64'(s_ready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    step();
    resetn = 1'b1;
    m_ready = 1'b1;
    step();
    check("arst_rel_s_ready", 64'(s_ready), 64'd1);
    send_wait(29'h0010000, 29'h0000000, "zero_coef0");
    take_output("zero_coef0");
    send_wait(29'h0030000, 29'h0000000, "zero_coef1");
    check("zero_coef_sat", 64'(sat), 64'd0);
    take_output("zero_coef1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iir_biquad_seq.md
# iir_biquad_seq

Sequencer for one direct-form-I IIR biquad section built around a single shared multiplier-accumulator. It accepts one sample per valid/ready handshake and steps the five coefficient taps through the multiplier in successive cycles. It then rounds and saturates the accumulated result, updates the x/y delay state, and presents the output sample downstream. It sits between the sample source and the next filter stage inside the FilterIIR IP, and replaces per-tap multipliers with one time-multiplexed MAC.

## Interface
- INT_BITS, 12, integer bits of the Q format (excluding sign)
- FRAC_BITS, 16, fractional bits of the Q format
- W (derived), INT_BITS+FRAC_BITS+1 = 29, signed sample/coefficient width
- ACC_W (derived), 2*(INT_BITS+FRAC_BITS)+1+3 = 60, internal accumulator width (57-bit product plus 3 guard bits)
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  W  input sample x[n], signed Q12.16
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output
- m_data  out  W  output sample y[n], signed Q12.16
- coef_we  in  1  coefficient write strobe
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored
- coef_data  in  W  coefficient value, signed Q12.16
- clear  in  1  synchronous abort and state clear
- busy  out  1  high in any state other than IDLE
- sat  out  1  sticky: an output was clamped

## Operation
- Equation: y[n] = b0·x[n] + b1·x1 + b2·x2 − a1·y1 − a2·y2. The a-terms are subtracted from the accumulator.
- FSM states: IDLE → MAC → RND → OUT → IDLE.
- IDLE: s_ready=1. On s_valid&&s_ready, latch s_data into x0, clear acc, set tap=0, go to MAC.
- MAC: one tap per cycle, tap 0..4 (b0·x0, b1·x1, b2·x2, a1·y1, a2·y2).
  - Each product is a full W×W signed product, sign-extended to ACC_W, then added or subtracted.
  - After tap 4, go to RND.
- RND, in a single cycle:
  - r = (acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS (arithmetic shift).
  - Clamp r to [−2^(W−1), 2^(W−1)−1]; if clamped, set sat.
  - Load m_data=r and shift the delay line: x2←x1, x1←x0, y2←y1, y1←r.
  - Set m_valid=1 and go to OUT.
- OUT: hold m_valid and m_data stable until m_ready. On m_valid&&m_ready, drop m_valid, set s_ready, go to IDLE.
- Coefficient writes:
  - Honoured only when busy=0; writes while busy are silently dropped.
  - Coefficients are used by the next sample.
- clear, in any state:
  - Next edge: zero x0, x1, x2, y1, y2, acc and sat; m_valid←0; state←IDLE; s_ready←1.
  - Any in-flight sample is discarded.
  - Coefficients are kept.
  - clear has priority over a simultaneous s_valid, m_ready or coef_we.
- Reset (resetn low, any time):
  - Immediately: state=IDLE, s_ready=0, m_valid=0, m_data=0, busy=0, sat=0.
  - All coefficients and delay state become 0.
  - s_ready rises on the first clk edge after resetn deasserts.

## Timing
- Accept at edge E0.
- MAC taps occupy edges E1..E5.
- RND at E6: m_valid is high after E6.
- Latency from accept to m_valid is 6 cycles.
- With m_ready held high, the output handshake completes at E7 and s_ready is high after E7.
- Maximum throughput is one sample per 8 cycles.
- s_ready and m_valid are never high together.
- s_ready, m_valid, m_data, busy and sat are registered outputs with no combinational input-to-output paths.
- m_ready low stalls only the OUT state; no sample is ever lost or duplicated.

## Test plan
- Passthrough:
  - Stimulus: b0=0x10000, other coefficients 0; send x=0x30000.
  - Required: m_data=0x30000 with m_valid high 6 cycles after accept; sat=0.
- Recursion:
  - Stimulus: b0=0x10000, a1=−0x8000 (y=x+0.5·y1); send impulse 0x10000 then three 0 samples.
  - Required: outputs 0x10000, 0x8000, 0x4000, 0x2000.
- Saturation:
  - Stimulus: b0=0x640000 (100.0); send x=0x640000.
  - Required: m_data=0x0FFFFFFF and sat=1. With x=−0x640000 instead, m_data=0x10000000 (most negative).
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after m_valid rises.
  - Required: m_valid and m_data stay stable and s_ready stays 0. A single output is taken when m_ready rises, and s_ready rises the next cycle.
- Clear mid-MAC and dropped write:
  - Stimulus: pulse clear 3 cycles after accept; then send x=0x10000 with b0=0x10000, b1=0x10000.
  - Required: no output for the aborted sample; the next output is 0x10000 because x1 was cleared.
  - Stimulus: a coef_we issued while busy.
  - Required: no effect on the coefficients.
- Async reset:
  - Stimulus: drop resetn while in OUT.
  - Required: m_valid=0 and m_data=0 without waiting for a clock edge, and s_ready=0. After release, s_ready=1 on the first edge, all coefficients read as 0 and any input yields y=0.
